// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Owns the single-port frame-buffer RAM that sits behind the VGA sync
// generator. Every clk cycle the port is given to exactly one user:
//   DISP  - display scan-out read, on a pixel-tick cycle inside the active area
//   WRITE - one of two drawing clients (0 = UI painter, 1 = cursor/text overlay)
//   IDLE  - nobody
// Display reads always win. The two clients share the remaining cycles
// round-robin. The low-resolution buffer (FB_W x FB_H) is upscaled by
// 2**SCALE_SHIFT in both directions by dropping the low bits of x and y. The
// module also produces the registered RGB stream for the DAC.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   p_tick            : pixel tick, high on alternate clk cycles
//   video_on          : active-area flag from the sync generator
//   x, y              : current column / row (10 bits each)
//   vblank_only       : 1 = client writes are only granted while y >= 480
//   req_valid[1:0]    : per-client write request, held until acknowledged
//   req_addr0/1       : client write addresses
//   req_data0/1       : client write data
//   req_ack[1:0]      : one-cycle pulse, request consumed
//   req_oob           : pulses together with req_ack when the address was out
//                       of range and the write was dropped
//   mem_addr/we/wdata : registered RAM port
//   mem_rdata         : RAM read data, valid one clk after mem_addr
//   rgb               : registered pixel to the DAC, 0 outside the active area
//   frame_start       : one-cycle pulse after a p_tick cycle with x==0, y==0
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              vblank_only,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ack,
  output logic              req_oob,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start
);

  // ---------------------------------------------------------------------------
  // Geometry constants
  // ---------------------------------------------------------------------------
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ACT_W   = FB_W << SCALE_SHIFT;
  localparam int ACT_H   = FB_H << SCALE_SHIFT;

  localparam logic [9:0]        ACT_W_X   = 10'(ACT_W);
  localparam logic [9:0]        ACT_H_Y   = 10'(ACT_H);
  localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
  // One bit wider than an address so FB_SIZE == 2**ADDR_W still compares right.
  localparam logic [ADDR_W:0]   FB_SIZE_W = (ADDR_W + 1)'(FB_SIZE);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_DISP  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]        req_ack_q,     req_ack_d;
  logic              req_oob_q,     req_oob_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic              mem_we_q,      mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [DATA_W-1:0] rgb_q,         rgb_d;
  logic              frame_start_q, frame_start_d;
  // Client that wins when both are eligible; cleared so client 0 goes first.
  logic              rr_q,          rr_d;
  // Read pipeline: stage 1 is the cycle mem_addr is presented, stage 2 is the
  // cycle mem_rdata is valid. disp_* marks a real display read, von_* carries
  // video_on so rgb can be blanked when the beam leaves the active area.
  logic              disp_p1_q,     disp_p1_d;
  logic              disp_p2_q,     disp_p2_d;
  logic              von_p1_q,      von_p1_d;
  logic              von_p2_q,      von_p2_d;

  // ---------------------------------------------------------------------------
  // Display address: drop the upscale bits, then row * FB_W + column.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] disp_row;
  logic [ADDR_W-1:0] disp_col;
  logic [ADDR_W-1:0] disp_addr;
  logic              in_active;
  logic              disp_hit;

  assign disp_row  = ADDR_W'(y >> SCALE_SHIFT);
  assign disp_col  = ADDR_W'(x >> SCALE_SHIFT);
  assign disp_addr = disp_row * FB_W_A + disp_col;

  // Guard against a sync generator that asserts video_on with x/y outside the
  // 640x480 window: such cycles must never turn into a read.
  assign in_active = (x < ACT_W_X) && (y < ACT_H_Y);
  assign disp_hit  = p_tick && video_on && in_active;

  // ---------------------------------------------------------------------------
  // Per-client request qualification
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] cl_addr [2];
  logic [DATA_W-1:0] cl_data [2];
  logic [1:0]        eligible;
  logic [1:0]        in_range;
  logic              vblank_ok;

  assign cl_addr[0] = req_addr0;
  assign cl_addr[1] = req_addr1;
  assign cl_data[0] = req_data0;
  assign cl_data[1] = req_data1;

  assign vblank_ok = !vblank_only || (y >= ACT_H_Y);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
      // A client whose ack is on the wire this cycle is still holding valid
      // from the request just consumed; granting it again would duplicate
      // the write, so it sits this cycle out.
      assign eligible[gi] = req_valid[gi] && !req_ack_q[gi] && vblank_ok;
      assign in_range[gi] = {1'b0, cl_addr[gi]} < FB_SIZE_W;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Slot decision
  // ---------------------------------------------------------------------------
  slot_e slot;
  logic  gnt_idx;

  always_comb begin
    slot    = SLOT_IDLE;
    gnt_idx = 1'b0;
    if (disp_hit) begin
      slot = SLOT_DISP;
    end else if (eligible != 2'b00) begin
      slot = SLOT_WRITE;
      if (eligible == 2'b11) begin
        gnt_idx = rr_q;
      end else begin
        gnt_idx = eligible[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ack_d     = 2'b00;
    req_oob_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rr_d          = rr_q;
    frame_start_d = p_tick && (x == 10'd0) && (y == 10'd0);

    unique case (slot)
      SLOT_DISP: begin
        mem_addr_d = disp_addr;
      end
      SLOT_WRITE: begin
        req_ack_d[gnt_idx] = 1'b1;
        rr_d               = ~gnt_idx;
        if (in_range[gnt_idx]) begin
          mem_addr_d  = cl_addr[gnt_idx];
          mem_wdata_d = cl_data[gnt_idx];
          mem_we_d    = 1'b1;
        end else begin
          // Consume the request so the client is not stuck, but never let an
          // out-of-range address reach the RAM.
          req_oob_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    disp_p1_d = (slot == SLOT_DISP);
    disp_p2_d = disp_p1_q;
    von_p1_d  = video_on;
    von_p2_d  = von_p1_q;

    // A fresh read result replaces the pixel. Between ticks inside the active
    // area the previous pixel is held, so each pixel lasts its full two
    // clocks; once video_on drops (delayed to match the read) rgb goes black.
    if (disp_p2_q) begin
      rgb_d = mem_rdata;
    end else if (!von_p2_q) begin
      rgb_d = '0;
    end else begin
      rgb_d = rgb_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ack_q     <= 2'b00;
      req_oob_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      rr_q          <= 1'b0;
      disp_p1_q     <= 1'b0;
      disp_p2_q     <= 1'b0;
      von_p1_q      <= 1'b0;
      von_p2_q      <= 1'b0;
    end else begin
      req_ack_q     <= req_ack_d;
      req_oob_q     <= req_oob_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      rr_q          <= rr_d;
      disp_p1_q     <= disp_p1_d;
      disp_p2_q     <= disp_p2_d;
      von_p1_q      <= von_p1_d;
      von_p2_q      <= von_p2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ack     = req_ack_q;
  assign req_oob     = req_oob_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule
